// File: rtl/sar_search_ctrl_pkg.sv
// sar_search_ctrl_pkg: shared state type, default width and flag-consistency check
package sar_search_ctrl_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;
  function automatic logic flags_ok(input logic lesser, input logic greater, input logic equal);
    return $onehot({lesser, greater, equal});
  endfunction
endpackage

// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: controller <-> comparator/downstream signal bundle
interface sar_search_ctrl_if import sar_search_ctrl_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic start, cmp_lesser, cmp_greater, cmp_equal, busy, done, early, err;
  logic [WIDTH-1:0] trial, result;
  modport master (
    input start, cmp_lesser, cmp_greater, cmp_equal,
    output trial, busy, done, result, early, err
  );
  modport slave (
    output start, cmp_lesser, cmp_greater, cmp_equal,
    input trial, busy, done, result, early, err
  );
endinterface

// File: rtl/sar_step.sv
// sar_step: one combinational successive-approximation step on the comparator flags
module sar_step import sar_search_ctrl_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] trial,
  input  logic [IW-1:0]    idx,
  input  logic             lesser,
  input  logic             greater,
  input  logic             equal,
  output logic [WIDTH-1:0] nxt_trial,
  output logic [WIDTH-1:0] value,
  output logic             term,
  output logic             hit,
  output logic             bad
);
  logic [WIDTH-1:0] one, work;
  always_comb begin
    one = WIDTH'(1);
    bad = !flags_ok(lesser, greater, equal);
    hit = equal && !bad;
    work = greater ? trial & ~(one << idx) : trial;
    term = bad || equal || idx == '0;
    value = (bad || equal) ? trial : work;
    nxt_trial = work | (one << (idx - IW'(1)));
  end
endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first search FSM driving an external magnitude comparator
module sar_search_ctrl import sar_search_ctrl_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst_n,
  sar_search_ctrl_if.master bus
);
  localparam int IW = $clog2(WIDTH);
  state_t state, nxt_state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] trial, result, nxt_trial, value;
  logic early, err, term, hit, bad;
  sar_step #(.WIDTH(WIDTH), .IW(IW)) u_step (
    .trial(trial),
    .idx(idx),
    .lesser(bus.cmp_lesser),
    .greater(bus.cmp_greater),
    .equal(bus.cmp_equal),
    .nxt_trial(nxt_trial),
    .value(value),
    .term(term),
    .hit(hit),
    .bad(bad)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= IW'(WIDTH - 1);
      trial <= '0;
      result <= '0;
      early <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && bus.start) begin
        trial <= {1'b1, {(WIDTH-1){1'b0}}};
        idx <= IW'(WIDTH - 1);
        early <= 1'b0;
        err <= 1'b0;
      end
      if (state == TRY && term) begin
        result <= value;
        early <= hit;
        err <= bad;
      end
      if (state == TRY && !term) begin
        trial <= nxt_trial;
        idx <= idx - IW'(1);
      end
    end
  end
  always_comb begin
    nxt_state = state == IDLE ? (bus.start ? TRY : IDLE) :
                state == TRY  ? (term ? DONE : TRY) : IDLE;
  end
  always_comb begin
    bus.trial = trial;
    bus.result = result;
    bus.early = early;
    bus.err = err;
    bus.busy = state == TRY;
    bus.done = state == DONE;
  end
endmodule
